// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module   : bcd_scan_display
// Purpose  : Periodically samples CHANNELS values, converts each to BCD with a
//            shared one-bit-per-cycle double-dabble engine, and holds
//            registered active-low seven-segment patterns between updates.
//            Optional macro BCD_SCAN_LZ_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_display #(
    parameter int CHANNELS    = 2,
    parameter int IN_WIDTH    = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*IN_WIDTH-1:0] in,
    output logic [CHANNELS*DIGITS*7-1:0] hex,
    output logic                         busy,
    output logic [CHANNELS-1:0]          ovf
);

    localparam int c_nib  = (IN_WIDTH + 2) / 3;
    localparam int c_bw   = 4 * c_nib;
    localparam int c_pnib = (c_nib > DIGITS) ? c_nib : DIGITS;
    localparam int c_pw   = 4 * c_pnib;
    localparam int c_cw   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_tw   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_bcw  = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;

    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [6:0] c_seg_dash  = 7'h3F;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_tw-1:0]         r_count;
    logic                    w_tick;
    logic [IN_WIDTH-1:0]     r_shadow [CHANNELS];
    logic [IN_WIDTH-1:0]     w_sel;
    logic [IN_WIDTH-1:0]     r_shreg;
    logic [c_bw-1:0]         r_bcd;
    logic [c_bw-1:0]         w_adj;
    logic [c_bw-1:0]         w_bcd_next;
    logic [c_pw-1:0]         w_pad;
    logic [c_bcw-1:0]        r_bitcnt;
    logic [c_cw-1:0]         r_ch;
    logic                    w_last_bit;
    logic                    w_last_ch;
    logic                    w_ovf;
    logic [DIGITS*7-1:0]     w_seg;
    logic [CHANNELS*DIGITS*7-1:0] r_hex;
    logic [CHANNELS-1:0]     r_ovf;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_tick     = (r_count == c_tw'(REFRESH_DIV - 1));
    assign w_last_bit = (r_bitcnt == c_bcw'(IN_WIDTH - 1));
    assign w_last_ch  = (r_ch == c_cw'(CHANNELS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_tw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_tick) w_state_next = c_st_load;
            c_st_load:  w_state_next = c_st_shift;
            c_st_shift: if (w_last_bit) w_state_next = w_last_ch ? c_st_idle : c_st_load;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_load) || (r_state == c_st_shift);
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_ch == c_cw'(k)) w_sel = r_shadow[k];
        end
    end

    // Double-dabble step: correct nibbles first, then shift the next input bit in.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < c_nib; i++) begin
            w_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3
                                                         : r_bcd[i*4 +: 4];
        end
        w_bcd_next = {w_adj[c_bw-2:0], r_shreg[IN_WIDTH-1]};
        w_pad = '0;
        w_pad[c_bw-1:0] = w_bcd_next;
    end

    // Segment patterns for the channel being committed, built from the final BCD value.
    always_comb begin
        logic lead;
        w_ovf = 1'b0;
        for (int i = DIGITS; i < c_pnib; i++) begin
            if (w_pad[i*4 +: 4] != 4'd0) w_ovf = 1'b1;
        end
        w_seg = '0;
        lead  = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (w_ovf) begin
                w_seg[j*7 +: 7] = c_seg_dash;
            end else begin
`ifdef BCD_SCAN_LZ_BLANK_EN
                if (lead && (j != 0) && (w_pad[j*4 +: 4] == 4'd0)) begin
                    w_seg[j*7 +: 7] = c_seg_blank;
                end else begin
                    lead            = 1'b0;
                    w_seg[j*7 +: 7] = seg7(w_pad[j*4 +: 4]);
                end
`else
                lead            = 1'b0;
                w_seg[j*7 +: 7] = seg7(w_pad[j*4 +: 4]);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) r_shadow[k] <= '0;
            r_shreg  <= '0;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_ch     <= '0;
            r_hex    <= '1;
            r_ovf    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            r_shadow[k] <= in[k*IN_WIDTH +: IN_WIDTH];
                        end
                        r_ch <= '0;
                    end
                end
                c_st_load: begin
                    r_shreg  <= w_sel;
                    r_bcd    <= '0;
                    r_bitcnt <= '0;
                end
                c_st_shift: begin
                    r_bcd    <= w_bcd_next;
                    r_shreg  <= r_shreg << 1;
                    r_bitcnt <= r_bitcnt + c_bcw'(1);
                    if (w_last_bit) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (r_ch == c_cw'(k)) begin
                                r_hex[k*DIGITS*7 +: DIGITS*7] <= w_seg;
                                r_ovf[k]                      <= w_ovf;
                            end
                        end
                        if (!w_last_ch) r_ch <= r_ch + c_cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hex = r_hex;
    assign ovf = r_ovf;

endmodule

`default_nettype wire
